// File: rtl/mem_pkg.sv
// Shared constants, request bundle and helpers for the banked main memory.
package mem_pkg;

  localparam int NUM_BANKS    = 4;
  localparam int BANK_W       = 2;
  localparam int BANK_SEL_LSB = 1;
  localparam int ROW_LSB      = 3;

  localparam int REQ_ADDR_W = 16;
  localparam int REQ_DATA_W = 16;

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [REQ_ADDR_W-1:0] addr;
    logic [REQ_DATA_W-1:0] data;
  } mem_req_t;

  // Busy counter holds BANK_BUSY-1; keep at least one bit.
  function automatic int cnt_width(input int busy_cycles);
    int w;
    w = $clog2(busy_cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mem_bank.sv
// One interleaved bank: storage, busy counter, write port and read register.
module mem_bank
  import mem_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 512,
  parameter int BANK_BUSY = 4,
  localparam int ROW_W    = $clog2(DEPTH),
  localparam int CNT_W    = cnt_width(BANK_BUSY)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              rd,
  input  logic              wr,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] LOAD = CNT_W'(BANK_BUSY - 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= LOAD;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept && wr) begin
      mem[row] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && rd) begin
      rdata <= mem[row];
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/banked_main_mem.sv
// Four-bank interleaved word memory behind the cache controller.
// Optional UNALIGNED_ERR_EN rejects odd byte addresses with err.
module banked_main_mem
  import mem_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 512,
  parameter int BANK_BUSY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  localparam int ROW_W = $clog2(DEPTH);

  logic              req;
  logic              unaligned;
  logic              accept;
  logic [BANK_W-1:0] bank;
  logic [ROW_W-1:0]  row;
  logic [DATA_W-1:0] rdata [NUM_BANKS];
  logic              rd_v;
  logic [BANK_W-1:0] rd_bank;

  assign bank = addr[BANK_SEL_LSB +: BANK_W];
  assign row  = addr[ROW_LSB +: ROW_W];
  assign req  = rd ^ wr;

`ifdef UNALIGNED_ERR_EN
  assign unaligned = req & addr[0];
`else
  assign unaligned = 1'b0;
`endif

  assign err    = (rd & wr) | unaligned;
  assign stall  = req & ~err & busy[bank];
  assign accept = req & ~stall & ~err & ~rst;

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    mem_bank #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .BANK_BUSY (BANK_BUSY)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .accept (accept && (bank == BANK_W'(g))),
      .rd     (rd),
      .wr     (wr),
      .row    (row),
      .wdata  (data_in),
      .rdata  (rdata[g]),
      .busy   (busy[g])
    );
  end

  // Stage 1 tracks which bank register holds the sampled word.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_v    <= 1'b0;
      rd_bank <= '0;
    end else begin
      rd_v    <= accept & rd;
      rd_bank <= bank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else begin
      data_out <= rd_v ? rdata[rd_bank] : '0;
    end
  end

  // Upper address bits alias onto the row; bit 0 is the byte lane.
  logic unused_addr;
  assign unused_addr = ^{addr[0], addr[ADDR_W-1:ROW_LSB+ROW_W]};

endmodule

// File: tb/tb_banked_main_mem.sv
// Bench for banked_main_mem: directed table, random vs. reference model, corner sequences.
module tb_banked_main_mem;
  import mem_pkg::*;

  localparam int BB      = 4;
  localparam int DEPTH_A = 512;
`ifdef UNALIGNED_ERR_EN
  localparam bit UNAL = 1'b1;
`else
  localparam bit UNAL = 1'b0;
`endif

  logic        clk = 1'b1;
  logic        rst, rd, wr;
  logic [15:0] addr, data_in, data_out;
  logic        stall, err;
  logic [3:0]  busy;

  logic        b_rd, b_wr;
  logic [15:0] b_addr, b_din, b_dout;
  logic        b_stall, b_err;
  logic [3:0]  b_busy;

  always #5 clk = ~clk;

  banked_main_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH_A), .BANK_BUSY(BB)) dut (
    .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .stall(stall), .busy(busy), .err(err)
  );

  banked_main_mem #(.DATA_W(16), .ADDR_W(16), .DEPTH(8), .BANK_BUSY(BB)) dut_small (
    .clk(clk), .rst(rst), .rd(b_rd), .wr(b_wr), .addr(b_addr), .data_in(b_din),
    .data_out(b_dout), .stall(b_stall), .busy(b_busy), .err(b_err)
  );

  int nvec = 0;
  int nbad = 0;
  int cyc  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: word map, per-bank free time, expected output by cycle.
  logic [15:0] mem_m [int];
  int          free_at [4];
  logic [15:0] dexp [int];
  logic [15:0] wlist [$];

  function automatic int key_of(input logic [15:0] a);
    return ((int'(a >> 3)) % DEPTH_A) * 4 + int'(a[2:1]);
  endfunction

  function automatic logic m_err();
    return (rd & wr) | (UNAL & (rd ^ wr) & addr[0]);
  endfunction

  function automatic logic [3:0] m_busy();
    logic [3:0] mb;
    for (int b = 0; b < 4; b++) mb[b] = (cyc < free_at[b]);
    return mb;
  endfunction

  function automatic logic m_stall();
    logic [3:0] mb;
    mb = m_busy();
    return (rd ^ wr) & ~m_err() & mb[addr[2:1]];
  endfunction

  function automatic logic [15:0] m_dout();
    return dexp.exists(cyc) ? dexp[cyc] : 16'h0000;
  endfunction

  task automatic advance();
    int k;
    k = key_of(addr);
    if (rst) begin
      for (int b = 0; b < 4; b++) free_at[b] = 0;
      if (dexp.exists(cyc + 1)) dexp.delete(cyc + 1);
      if (dexp.exists(cyc + 2)) dexp.delete(cyc + 2);
    end else if ((rd ^ wr) && !m_err() && !m_stall()) begin
      free_at[addr[2:1]] = cyc + BB;
      if (wr) begin
        mem_m[k] = data_in;
        wlist.push_back(addr);
      end else begin
        dexp[cyc + 2] = mem_m.exists(k) ? mem_m[k] : 16'h0000;
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_main();
    rst = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
  endtask

  typedef struct {
    logic       rs;
    mem_req_t   req;
    logic       chk;
    logic       st;
    logic       er;
    logic [3:0] bz;
    logic [15:0] dq;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic rs, input logic r, input logic w,
                              input logic [15:0] a, input logic [15:0] d,
                              input logic c, input logic st, input logic er,
                              input logic [3:0] bz, input logic [15:0] dq);
    vec_t v;
    v.rs = rs; v.req.rd = r; v.req.wr = w; v.req.addr = a; v.req.data = d;
    v.chk = c; v.st = st; v.er = er; v.bz = bz; v.dq = dq;
    return v;
  endfunction

  initial begin
    idle_main();
    rst = 1'b1;
    b_rd = 1'b0; b_wr = 1'b0; b_addr = 16'h0; b_din = 16'h0;
    for (int b = 0; b < 4; b++) free_at[b] = 0;

    //                rs r  w  addr     data     chk st er busy     dout
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 4'b0000, 16'h0000));
    tbl.push_back(mk(1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b0000, 16'h0000));
    tbl.push_back(mk(0, 0, 1, 16'h0040, 16'h1111, 1, 0, 0, 4'b0000, 16'h0000));
    tbl.push_back(mk(0, 0, 1, 16'h0042, 16'h2222, 1, 0, 0, 4'b0001, 16'h0000));
    tbl.push_back(mk(0, 0, 1, 16'h0044, 16'h3333, 1, 0, 0, 4'b0011, 16'h0000));
    tbl.push_back(mk(0, 0, 1, 16'h0046, 16'h4444, 1, 0, 0, 4'b0111, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 16'h0040, 16'h0000, 1, 0, 0, 4'b1110, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 16'h0042, 16'h0000, 1, 0, 0, 4'b1101, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 16'h0044, 16'h0000, 1, 0, 0, 4'b1011, 16'h1111));
    tbl.push_back(mk(0, 1, 0, 16'h0046, 16'h0000, 1, 0, 0, 4'b0111, 16'h2222));
    tbl.push_back(mk(0, 0, 1, 16'h0048, 16'h5555, 1, 0, 0, 4'b1110, 16'h3333));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b1101, 16'h4444));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b1001, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b0001, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 16'h0040, 16'h0000, 1, 0, 0, 4'b0000, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 16'h0048, 16'h0000, 1, 1, 0, 4'b0001, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 16'h0048, 16'h0000, 1, 1, 0, 4'b0001, 16'h1111));
    tbl.push_back(mk(0, 1, 0, 16'h0048, 16'h0000, 1, 1, 0, 4'b0001, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 16'h0048, 16'h0000, 1, 0, 0, 4'b0000, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b0001, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b0001, 16'h5555));
    tbl.push_back(mk(0, 1, 1, 16'h0044, 16'hDEAD, 1, 0, 1, 4'b0001, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b0000, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 16'h0044, 16'h0000, 1, 0, 0, 4'b0000, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b0100, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b0100, 16'h3333));
    tbl.push_back(mk(0, 1, 0, 16'h0042, 16'h0000, 1, 0, 0, 4'b0100, 16'h0000));
    tbl.push_back(mk(1, 0, 1, 16'h0046, 16'h9999, 1, 0, 0, 4'b0010, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 16'h0042, 16'h0000, 1, 0, 0, 4'b0000, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b0010, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b0010, 16'h2222));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b0010, 16'h0000));
    tbl.push_back(mk(0, 1, 0, 16'h0046, 16'h0000, 1, 0, 0, 4'b0000, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b1000, 16'h0000));
    tbl.push_back(mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 4'b1000, 16'h4444));

    foreach (tbl[i]) begin
      rst = tbl[i].rs; rd = tbl[i].req.rd; wr = tbl[i].req.wr;
      addr = tbl[i].req.addr; data_in = tbl[i].req.data;
      @(negedge clk);
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_stall", i), 16'(stall), 16'(tbl[i].st));
        chk($sformatf("tbl%0d_err", i), 16'(err), 16'(tbl[i].er));
        chk($sformatf("tbl%0d_busy", i), 16'(busy), 16'(tbl[i].bz));
        chk($sformatf("tbl%0d_dout", i), data_out, tbl[i].dq);
      end
      advance();
    end

    // Randomized traffic against the model; stalled requests are held.
    begin
      logic hold;
      hold = 1'b0;
      for (int n = 0; n < 600; n++) begin
        if (!hold) begin
          int c;
          c = int'($urandom_range(0, 99));
          idle_main();
          rst = ($urandom_range(0, 79) == 0);
          addr = 16'($urandom_range(0, 127));
          data_in = 16'($urandom);
          if (c < 40) begin
            wr = 1'b1;
          end else if (c < 75) begin
            rd = 1'b1;
            addr = wlist[$urandom_range(0, wlist.size() - 1)];
            addr[0] = 1'($urandom_range(0, 1));
          end else if (c < 80) begin
            rd = 1'b1;
            wr = 1'b1;
          end
        end else begin
          rst = 1'b0;
        end
        @(negedge clk);
        chk("rnd_stall", 16'(stall), 16'(m_stall()));
        chk("rnd_err", 16'(err), 16'(m_err()));
        chk("rnd_busy", 16'(busy), 16'(m_busy()));
        chk("rnd_dout", data_out, m_dout());
        hold = m_stall() & ~rst;
        advance();
      end
    end

    // Odd address after an aligned write.
    idle_main();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      advance();
    end
    wr = 1'b1; addr = 16'h0040; data_in = 16'hBEEF;
    @(negedge clk);
    chk("un_wr_stall", 16'(stall), 16'h0);
    advance();
    idle_main();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      advance();
    end
    rd = 1'b1; addr = 16'h0041;
    @(negedge clk);
    chk("un_rd_err", 16'(err), 16'(UNAL));
    chk("un_rd_stall", 16'(stall), 16'h0);
    advance();
    idle_main();
    @(negedge clk);
    chk("un_busy", 16'(busy), UNAL ? 16'h0000 : 16'h0001);
    advance();
    @(negedge clk);
    chk("un_dout", data_out, UNAL ? 16'h0000 : 16'hBEEF);
    advance();

    // Row aliasing on the small instance.
    b_wr = 1'b1; b_addr = 16'h0000; b_din = 16'h5A5A;
    @(negedge clk);
    chk("alias_wr_stall", 16'(b_stall), 16'h0);
    advance();
    b_wr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      advance();
    end
    b_rd = 1'b1; b_addr = 16'h0040;
    @(negedge clk);
    chk("alias_rd_stall", 16'(b_stall), 16'h0);
    chk("alias_rd_err", 16'(b_err), 16'h0);
    advance();
    b_rd = 1'b0;
    @(negedge clk);
    chk("alias_busy", 16'(b_busy), 16'h0001);
    chk("alias_dout_early", b_dout, 16'h0000);
    advance();
    @(negedge clk);
    chk("alias_dout", b_dout, 16'h5A5A);
    advance();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
